// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use detection, multi-cycle multdiv sequencing,
// taken-branch flush and a saturating stall-cycle counter for the 5-stage core.
module hazard_stall_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dx_is_load,
    input  logic [4:0]       dx_rd,
    input  logic [4:0]       fd_rs,
    input  logic [4:0]       fd_rt,
    input  logic             fd_uses_rs,
    input  logic             fd_uses_rt,
    input  logic             md_start,
    input  logic             md_ready,
    input  logic             branch_taken,
    output logic             stall_pc,
    output logic             stall_fd,
    output logic             stall_dx,
    output logic             bubble_dx,
    output logic             bubble_xm,
    output logic             flush_fd,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    // md_cnt only needs to reach MD_TIMEOUT-1 before the abort fires.
    localparam int MDC_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [MDC_W-1:0] MD_LAST = MDC_W'(MD_TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        MD_BUSY
    } state_t;

    state_t           state, next_state;
    logic [MDC_W-1:0] md_cnt, md_cnt_next;
    logic             set_timeout;

    logic rs_hit, rt_hit, lu_hazard;

    // Register $0 is hardwired to zero, so writing it never creates a dependency.
    assign rs_hit    = fd_uses_rs & (fd_rs == dx_rd) & (dx_rd != 5'd0);
    assign rt_hit    = fd_uses_rt & (fd_rt == dx_rd) & (dx_rd != 5'd0);
    assign lu_hazard = dx_is_load & (rs_hit | rt_hit);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        next_state  = state;
        md_cnt_next = md_cnt;
        set_timeout = 1'b0;
        stall_pc    = 1'b0;
        stall_fd    = 1'b0;
        stall_dx    = 1'b0;
        bubble_dx   = 1'b0;
        bubble_xm   = 1'b0;
        flush_fd    = 1'b0;
        md_busy     = 1'b0;

        unique case (state)
            IDLE: begin
                // A taken branch squashes the F/D instruction, so its hazard is moot.
                if (branch_taken) begin
                    flush_fd  = 1'b1;
                    bubble_dx = 1'b1;
                end else if (lu_hazard) begin
                    stall_pc  = 1'b1;
                    stall_fd  = 1'b1;
                    bubble_dx = 1'b1;
                end
                if (md_start && !md_ready) begin
                    next_state  = MD_BUSY;
                    md_cnt_next = '0;
                end
            end

            MD_BUSY: begin
                if (md_ready) begin
                    // Release everything this cycle so the result lands in X/M.
                    next_state  = IDLE;
                    md_cnt_next = '0;
                end else begin
                    stall_pc  = 1'b1;
                    stall_fd  = 1'b1;
                    stall_dx  = 1'b1;
                    bubble_xm = 1'b1;
                    md_busy   = 1'b1;
                    if (md_cnt == MD_LAST) begin
                        next_state  = IDLE;
                        md_cnt_next = '0;
                        set_timeout = 1'b1;
                    end else begin
                        md_cnt_next = md_cnt + 1'b1;
                    end
                end
            end

            default: begin
                next_state  = IDLE;
                md_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            md_cnt     <= '0;
            md_timeout <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops sample pre-edge values.
            state  <= next_state;
            md_cnt <= md_cnt_next;
            if (set_timeout) begin
                md_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall_pc && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares; a CNT_W=3 copy checks counter saturation.
module tb_hazard_stall_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       dx_is_load;
    logic [4:0] dx_rd, fd_rs, fd_rt;
    logic       fd_uses_rs, fd_uses_rt;
    logic       md_start, md_ready, branch_taken;

    logic        stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd, md_busy, md_timeout;
    logic [15:0] stall_cycles;

    logic        s_stall_pc, s_stall_fd, s_stall_dx, s_bubble_dx, s_bubble_xm, s_flush_fd, s_md_busy, s_md_timeout;
    logic [2:0]  s_stall_cycles;

    typedef struct {
        logic [6:0]  ctl;   // {stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd, md_busy}
        logic        to;
        logic [15:0] cnt;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt  = 0;
    logic exp_to   = 1'b0;

    localparam logic [6:0] E_IDLE = 7'b0000000;
    localparam logic [6:0] E_LU   = 7'b1101000;
    localparam logic [6:0] E_BR   = 7'b0001010;
    localparam logic [6:0] E_MD   = 7'b1110101;

    always #5 clock = ~clock;

    hazard_stall_ctrl #(.MD_TIMEOUT(40), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .dx_is_load(dx_is_load), .dx_rd(dx_rd),
        .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
        .md_start(md_start), .md_ready(md_ready), .branch_taken(branch_taken),
        .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_dx(stall_dx),
        .bubble_dx(bubble_dx), .bubble_xm(bubble_xm), .flush_fd(flush_fd),
        .md_busy(md_busy), .md_timeout(md_timeout), .stall_cycles(stall_cycles)
    );

    hazard_stall_ctrl #(.MD_TIMEOUT(40), .CNT_W(3)) dut_sat (
        .clock(clock), .reset(reset), .dx_is_load(dx_is_load), .dx_rd(dx_rd),
        .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
        .md_start(md_start), .md_ready(md_ready), .branch_taken(branch_taken),
        .stall_pc(s_stall_pc), .stall_fd(s_stall_fd), .stall_dx(s_stall_dx),
        .bubble_dx(s_bubble_dx), .bubble_xm(s_bubble_xm), .flush_fd(s_flush_fd),
        .md_busy(s_md_busy), .md_timeout(s_md_timeout), .stall_cycles(s_stall_cycles)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: the DUT presents its controls every cycle; sample mid-cycle.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] sat;
            e = exp_q.pop_front();
            sat = (e.cnt > 16'd7) ? 32'd7 : 32'(e.cnt);
            check({e.tag, ":controls"},
                  {25'd0, stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd, md_busy},
                  {25'd0, e.ctl});
            check({e.tag, ":md_timeout"}, {31'd0, md_timeout}, {31'd0, e.to});
            check({e.tag, ":stall_cycles"}, {16'd0, stall_cycles}, {16'd0, e.cnt});
            check({e.tag, ":stall_cycles_sat3"}, {29'd0, s_stall_cycles}, sat);
        end
    end

    // One cycle of stimulus; the expectation is queued before the monitor samples.
    task automatic step(input string tag, input logic rst_v, input logic ld,
                        input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic mds, input logic mdr,
                        input logic br, input logic [6:0] ctl);
        exp_t e;
        reset        = rst_v;
        dx_is_load   = ld;
        dx_rd        = rd;
        fd_rs        = rs;
        fd_rt        = rt;
        fd_uses_rs   = urs;
        fd_uses_rt   = urt;
        md_start     = mds;
        md_ready     = mdr;
        branch_taken = br;
        if (rst_v) begin
            exp_cnt = 0;
            exp_to  = 1'b0;
        end
        e.ctl = ctl;
        e.to  = exp_to;
        e.cnt = 16'(exp_cnt);
        e.tag = tag;
        exp_q.push_back(e);
        if (ctl[6] && !rst_v) exp_cnt++;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        {dx_is_load, dx_rd, fd_rs, fd_rt, fd_uses_rs, fd_uses_rt, md_start, md_ready, branch_taken} = '0;
        repeat (2) @(posedge clock);
        #1;
        step("reset", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        idle("idle0");

        // Load-use hazards via rs and rt; stall only for the hazard cycle.
        step("lu_rs", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_LU);
        idle("after_lu");
        step("lu_rt", 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
        // No-hazard cases: $0, unused source, non-load producer, mismatched regs.
        step("r0",     1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);
        step("no_use", 1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        step("no_ld",  1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);
        step("diff",   1'b0, 1'b1, 5'd9, 5'd8, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);

        // Branch beats load-use; branch alone.
        step("br_lu", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_BR);
        step("br",    1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_BR);

        // md_ready alone is ignored; zero-latency op never enters MD_BUSY.
        step("rdy_only", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_IDLE);
        step("md_zero",  1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_IDLE);
        idle("after_zero");

        // Multdiv: four busy cycles, branch and hazard in the middle are ignored.
        step("md_go",  1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_IDLE);
        step("md_b1",  1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_MD);
        step("md_b2",  1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_MD);
        step("md_b3",  1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_MD);
        step("md_b4",  1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_MD);
        step("md_rdy", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_IDLE);
        idle("md_done");

        // md_start with branch+hazard: outputs follow IDLE priority, still goes busy.
        step("md_go_br", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, E_BR);
        step("md_b1_2",  1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_MD);
        step("md_rdy2",  1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_IDLE);

        // Timeout: exactly 40 busy cycles, then sticky md_timeout.
        step("to_go", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_IDLE);
        for (int i = 0; i < 40; i++) begin
            step("to_busy", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_MD);
        end
        exp_to = 1'b1;
        idle("to_after");
        idle("to_sticky");

        // Async reset between edges on the third busy cycle.
        step("ar_go", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_IDLE);
        step("ar_b1", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_MD);
        step("ar_b2", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_MD);
        step("ar_rst", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        idle("ar_rel");
        step("ar_lu", 1'b0, 1'b1, 5'd31, 5'd0, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
        idle("ar_end");

        @(negedge clock);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the 5-stage processor.
- Compares 5-bit register specifiers across stages to detect load-use hazards.
- Sequences multi-cycle multdiv operations, applies taken-branch flushes and drives the stall/bubble/flush controls of the PC, F/D, D/X and X/M latches.
- Keeps a saturating count of stall cycles for performance debug.

Parameters:
MD_TIMEOUT, 40, maximum cycles in MD_BUSY before forced abort
CNT_W, 16, width of stall-cycle counter

Ports:
clock  input  1  pipeline clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
dx_is_load  input  1  instruction in D/X is lw
dx_rd  input  5  destination register of D/X instruction
fd_rs  input  5  source register A of F/D instruction
fd_rt  input  5  source register B of F/D instruction
fd_uses_rs  input  1  F/D instruction reads rs
fd_uses_rt  input  1  F/D instruction reads rt
md_start  input  1  mult/div in X stage this cycle (start pulse)
md_ready  input  1  multdiv result valid
branch_taken  input  1  branch/jump resolved taken in X
stall_pc  output  1  hold PC
stall_fd  output  1  hold F/D latch
stall_dx  output  1  hold D/X latch
bubble_dx  output  1  insert nop into D/X
bubble_xm  output  1  insert nop into X/M
flush_fd  output  1  replace F/D with nop
md_busy  output  1  controller in MD_BUSY
md_timeout  output  1  sticky: multdiv abort occurred
stall_cycles  output  CNT_W  saturating count of cycles with stall_pc=1

Behaviour:
- Reset (async, immediate): state=IDLE, md_cnt=0, md_timeout=0, stall_cycles=0. All other outputs are combinational and go low when state=IDLE and all inputs are 0.
- Register match:
  - rs_hit = fd_uses_rs & (fd_rs==dx_rd) & (dx_rd!=0).
  - rt_hit likewise using fd_uses_rt and fd_rt.
  - Register 0 never causes a hazard.
- lu_hazard = dx_is_load & (rs_hit | rt_hit).
- States: IDLE, MD_BUSY.
- IDLE outputs, same cycle, priority order:
  1. branch_taken: flush_fd=1, bubble_dx=1; no stall, even if lu_hazard.
  2. lu_hazard: stall_pc=1, stall_fd=1, bubble_dx=1 for exactly that cycle. The hazard clears once the load advances.
  3. Otherwise all controls 0.
- IDLE -> MD_BUSY when md_start=1 and md_ready=0.
  - md_start takes precedence over lu_hazard and branch_taken for the next-state decision.
  - Same-cycle outputs still follow the IDLE priority list.
- md_start=1 with md_ready=1 in the same cycle: zero-latency op; stay in IDLE, no stall.
- MD_BUSY outputs:
  - stall_pc=stall_fd=stall_dx=1, bubble_xm=1, md_busy=1.
  - branch_taken and lu_hazard are ignored.
  - md_cnt increments each cycle.
- MD_BUSY with md_ready=1:
  - All stall outputs deassert in that same cycle so the result is latched into X/M.
  - Next state IDLE, md_cnt=0.
- MD_BUSY with md_cnt==MD_TIMEOUT-1 and md_ready=0:
  - md_timeout<=1 (sticky until reset).
  - Next state IDLE, md_cnt=0.
  - Stalls remain asserted that cycle.
- md_ready in IDLE without md_start: ignored.
- stall_cycles increments on each rising edge where stall_pc=1 and saturates at all-ones.
- Reset asserted mid-MD_BUSY: outputs drop to IDLE values immediately, without waiting for a clock edge.

Test Plan:
- Load-use hit: dx_is_load=1, dx_rd=5, fd_rs=5, fd_uses_rs=1 for one cycle -> stall_pc=stall_fd=bubble_dx=1 for that cycle only; stall_cycles=1.
- $0 exclusion: dx_is_load=1, dx_rd=0, fd_rs=0, fd_uses_rs=1 -> no stall. Same with fd_uses_rs=0, fd_rs=5=dx_rd -> no stall.
- Multdiv: md_start pulse, md_ready at 4th cycle after -> md_busy and stalls high for 4 cycles, low in ready cycle; stall_cycles=4; branch_taken pulsed mid-op has no effect.
- Timeout: md_start, md_ready never -> MD_BUSY for exactly 40 cycles, md_timeout=1 afterward, returns IDLE, stall_cycles=40.
- Branch vs load-use: branch_taken=1 with lu_hazard=1 -> flush_fd=1, bubble_dx=1, stall_pc=0.
- Async reset at cycle 3 of MD_BUSY (between edges) -> md_busy and stalls drop immediately; stall_cycles=0, md_timeout=0.
